// File: rtl/hqm_system_mem_fifo_pkg.sv
// Shared sizing defaults and output-buffer entry type for the SRAM-backed FIFO.
package hqm_system_mem_fifo_pkg;

  localparam int unsigned DEPTH  = 2048;
  localparam int unsigned DWIDTH = 16;
  localparam int unsigned AWIDTH = $clog2(DEPTH);

  // One slot of the output skid buffer
  typedef struct packed {
    logic [DWIDTH-1:0] data;
  } ob_entry_t;

endpackage

// File: rtl/hqm_system_mem_fifo_2048x16_ctl_if.sv
// Producer/consumer handshakes and single-port SRAM bus of the FIFO controller.
interface hqm_system_mem_fifo_2048x16_ctl_if #(
  parameter int unsigned DWIDTH = hqm_system_mem_fifo_pkg::DWIDTH,
  parameter int unsigned AWIDTH = hqm_system_mem_fifo_pkg::AWIDTH
);

  logic              push;
  logic [DWIDTH-1:0] push_data;
  logic              push_ready;
  logic              pop_valid;
  logic [DWIDTH-1:0] pop_data;
  logic              pop_ready;
  logic              mem_re;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;
  logic              mem_pwr_enable_b;

  // Controller side
  modport slave (
    input  push, push_data, pop_ready, mem_rdata, mem_pwr_enable_b,
    output push_ready, pop_valid, pop_data, mem_re, mem_we, mem_addr, mem_wdata
  );

  // Client + SRAM macro side
  modport master (
    output push, push_data, pop_ready, mem_rdata, mem_pwr_enable_b,
    input  push_ready, pop_valid, pop_data, mem_re, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/hqm_system_mem_fifo_skid2.sv
// Two-entry output skid buffer holding prefetched SRAM words ahead of the consumer.
module hqm_system_mem_fifo_skid2
  import hqm_system_mem_fifo_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wr_en_i,
  input  ob_entry_t wr_entry_i,
  input  logic      rd_en_i,
  output logic [1:0] count_o,
  output ob_entry_t head_o
);

  ob_entry_t  slot0_q;
  ob_entry_t  slot1_q;
  logic       wsel_q;
  logic       rsel_q;
  logic [1:0] cnt_q;

  // Slot storage, ping-pong pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      if (wr_en_i && !wsel_q) slot0_q <= wr_entry_i;
      if (wr_en_i &&  wsel_q) slot1_q <= wr_entry_i;
      if (wr_en_i) wsel_q <= !wsel_q;
      if (rd_en_i) rsel_q <= !rsel_q;
      cnt_q <= cnt_q + 2'(wr_en_i) - 2'(rd_en_i);
    end
  end

  assign count_o = cnt_q;
  assign head_o  = rsel_q ? slot1_q : slot0_q;

endmodule

// File: rtl/hqm_system_mem_fifo_2048x16_ctl.sv
// Controller for a FIFO stored in a single-port power-gated SRAM, with a
// two-entry prefetch buffer and round-robin read/write port arbitration.
module hqm_system_mem_fifo_2048x16_ctl #(
  parameter int unsigned DEPTH  = hqm_system_mem_fifo_pkg::DEPTH,
  parameter int unsigned DWIDTH = hqm_system_mem_fifo_pkg::DWIDTH,
  parameter int unsigned AWIDTH = hqm_system_mem_fifo_pkg::AWIDTH
) (
  input  logic                              clk,
  input  logic                              clk_rst_n,
  hqm_system_mem_fifo_2048x16_ctl_if.slave  bus,
  output logic [AWIDTH:0]                   fifo_depth,
  output logic                              fifo_empty,
  output logic                              fifo_full,
  output logic                              err_pwr_loss
);
  import hqm_system_mem_fifo_pkg::*;

  localparam int unsigned CW = AWIDTH + 1;

  logic [AWIDTH-1:0] wptr_q, wptr_d;
  logic [AWIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic              rr_rd_q, rr_rd_d;
  logic              err_q, err_d;
  logic              act_q;

  logic       pwr_ok;
  logic       full;
  logic       pop_fire;
  logic       rd_req;
  logic       rd_grant;
  logic       wr_fire;
  logic       pwr_loss;
  logic [1:0] ob_count;
  logic [1:0] ob_after;
  ob_entry_t  ob_in;
  ob_entry_t  ob_head;

  // Request/grant decode for the shared SRAM port
  assign pwr_ok   = !bus.mem_pwr_enable_b;
  assign full     = (cnt_q == CW'(DEPTH));
  assign pop_fire = bus.pop_valid && bus.pop_ready;
  assign ob_after = ob_count - 2'(pop_fire);
  assign rd_req   = pwr_ok && (cnt_q != '0) && ((ob_after + 2'(inflight_q)) < 2'd2);
  assign rd_grant = rd_req && (rr_rd_q || !bus.push || full);
  assign bus.push_ready = act_q && pwr_ok && !full && !(rd_req && rr_rd_q);
  assign wr_fire  = bus.push && bus.push_ready;
  assign pwr_loss = !pwr_ok && ((cnt_q != '0) || inflight_q);

  // SRAM command outputs; write and read grants are mutually exclusive
  assign bus.mem_we    = wr_fire;
  assign bus.mem_re    = rd_grant;
  assign bus.mem_addr  = wr_fire ? wptr_q : (rd_grant ? rptr_q : AWIDTH'(0));
  assign bus.mem_wdata = wr_fire ? bus.push_data : DWIDTH'(0);

  // Next-state for pointers, count, read pipeline, arbiter and error flag
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    inflight_d = rd_grant;
    rr_rd_d    = rr_rd_q;
    err_d      = err_q;
    if (pwr_loss) begin
      wptr_d     = '0;
      rptr_d     = '0;
      cnt_d      = '0;
      inflight_d = 1'b0;
      err_d      = 1'b1;
    end else begin
      if (wr_fire)  wptr_d = wptr_q + AWIDTH'(1);
      if (rd_grant) rptr_d = rptr_q + AWIDTH'(1);
      cnt_d = cnt_q + CW'(wr_fire) - CW'(rd_grant);
      if (rd_req && bus.push && !full) rr_rd_d = !rd_grant;
    end
  end

  // State registers; act_q holds off pushes until the first edge after reset
  always_ff @(posedge clk or negedge clk_rst_n) begin
    if (!clk_rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      rr_rd_q    <= 1'b0;
      err_q      <= 1'b0;
      act_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      rr_rd_q    <= rr_rd_d;
      err_q      <= err_d;
      act_q      <= 1'b1;
    end
  end

  // Returning read data lands in the skid buffer the cycle after mem_re
  assign ob_in.data = bus.mem_rdata;

  hqm_system_mem_fifo_skid2 u_skid (
    .clk        (clk),
    .rst_n      (clk_rst_n),
    .wr_en_i    (inflight_q),
    .wr_entry_i (ob_in),
    .rd_en_i    (pop_fire),
    .count_o    (ob_count),
    .head_o     (ob_head)
  );

  assign bus.pop_valid = (ob_count != 2'd0);
  assign bus.pop_data  = ob_head.data;

  // Status
  assign fifo_depth   = cnt_q + CW'(inflight_q) + CW'(ob_count);
  assign fifo_empty   = (fifo_depth == '0);
  assign fifo_full    = full;
  assign err_pwr_loss = err_q;

endmodule

// File: tb/tb_hqm_system_mem_fifo_2048x16_ctl.sv
// Scoreboard bench: accepted pushes feed an expected-order queue, pops are
// compared against it; directed phases cover latency, fill/drain, contention,
// wrap, power loss and reset mid-stream.
module tb_hqm_system_mem_fifo_2048x16_ctl;
  import hqm_system_mem_fifo_pkg::*;

  localparam int unsigned DW  = DWIDTH;
  localparam int unsigned AW  = AWIDTH;
  localparam int unsigned DEP = DEPTH;

  logic          clk;
  logic          clk_rst_n;
  logic [AW:0]   fifo_depth;
  logic          fifo_empty;
  logic          fifo_full;
  logic          err_pwr_loss;

  hqm_system_mem_fifo_2048x16_ctl_if bus ();

  hqm_system_mem_fifo_2048x16_ctl dut (
    .clk          (clk),
    .clk_rst_n    (clk_rst_n),
    .bus          (bus),
    .fifo_depth   (fifo_depth),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .err_pwr_loss (err_pwr_loss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: read data appears one cycle after mem_re
  logic [DW-1:0] sram [DEP];
  logic [DW-1:0] rdata_q;
  always @(posedge clk) begin
    if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) rdata_q <= sram[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  int            n_tests;
  int            n_fail;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_word;

  // Monitor: score pops against the expected queue, record accepted pushes
  always @(negedge clk) begin
    if (clk_rst_n) begin
      if (bus.pop_valid && bus.pop_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h required no pop", bus.pop_data);
        end else begin
          exp_word = exp_q.pop_front();
          if (bus.pop_data !== exp_word) begin
            n_fail++;
            $display("FAIL pop_data: got 0x%0h required 0x%0h", bus.pop_data, exp_word);
          end
        end
      end
      if (bus.push && bus.push_ready) exp_q.push_back(bus.push_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_push_ready"}, 32'(bus.push_ready), 32'd0);
    chk({tag, "_pop_valid"},  32'(bus.pop_valid),  32'd0);
    chk({tag, "_mem_re"},     32'(bus.mem_re),     32'd0);
    chk({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
    chk({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
    chk({tag, "_fifo_depth"}, 32'(fifo_depth),     32'd0);
    chk({tag, "_fifo_empty"}, 32'(fifo_empty),     32'd1);
    chk({tag, "_fifo_full"},  32'(fifo_full),      32'd0);
    chk({tag, "_err"},        32'(err_pwr_loss),   32'd0);
    chk({tag, "_pop_data"},   32'(bus.pop_data),   32'd0);
    chk({tag, "_mem_wdata"},  32'(bus.mem_wdata),  32'd0);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    bus.push      = 1'b1;
    bus.push_data = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = bus.push_ready;
      tick();
    end
    bus.push = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    bus.push      = 1'b0;
    bus.pop_ready = 1'b1;
    for (int i = 0; i < 6000 && !ok; i++) begin
      tick();
      ok = (exp_q.size() == 0) && fifo_empty;
    end
    chk({tag, "_empty"},     32'(fifo_empty),   32'd1);
    chk({tag, "_leftover"},  32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_random(input string tag, input int n_push, input int push_pct, input int pop_pct);
    int acc;
    int cyc;
    bit took;
    acc = 0;
    cyc = 0;
    bus.push = 1'b0;
    while (acc < n_push && cyc < 30000) begin
      if (!bus.push) begin
        bus.push      = ($urandom_range(99) < 32'(push_pct));
        bus.push_data = DW'($urandom);
      end
      bus.pop_ready = ($urandom_range(99) < 32'(pop_pct));
      @(negedge clk);
      took = bus.push && bus.push_ready;
      tick();
      if (took) begin
        acc++;
        bus.push = 1'b0;
      end
      cyc++;
    end
    bus.push = 1'b0;
    chk({tag, "_pushes_done"}, 32'(acc), 32'(n_push));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clk_rst_n = 1'b0;
    #1;
    exp_q.delete();
    tick();
    @(negedge clk);
    clk_rst_n = 1'b1;
    tick();
  endtask

  logic we_s, re_s, prev_we, took_s;
  bit   seen;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk_rst_n            = 1'b1;
    bus.push             = 1'b1;
    bus.push_data        = DW'(16'h1234);
    bus.pop_ready        = 1'b1;
    bus.mem_pwr_enable_b = 1'b0;
    #2 clk_rst_n = 1'b0;
    #10;
    check_reset_outputs("rst");
    @(negedge clk);
    clk_rst_n = 1'b1;
    bus.push  = 1'b0;
    tick();
    tick();

    // Latency from empty: push at N, mem_re at N+1, pop at N+3
    bus.pop_ready = 1'b1;
    bus.push      = 1'b1;
    bus.push_data = DW'(16'hA5A5);
    @(negedge clk);
    chk("lat_push_ready", 32'(bus.push_ready), 32'd1);
    chk("lat_mem_we",     32'(bus.mem_we),     32'd1);
    chk("lat_mem_wdata",  32'(bus.mem_wdata),  32'hA5A5);
    tick();
    bus.push = 1'b0;
    @(negedge clk);
    chk("lat_n1_mem_re",    32'(bus.mem_re),    32'd1);
    chk("lat_n1_pop_valid", 32'(bus.pop_valid), 32'd0);
    @(negedge clk);
    chk("lat_n2_pop_valid", 32'(bus.pop_valid), 32'd0);
    @(negedge clk);
    chk("lat_n3_pop_valid", 32'(bus.pop_valid), 32'd1);
    chk("lat_n3_pop_data",  32'(bus.pop_data),  32'hA5A5);
    tick();
    drain("lat");

    // Fill to full with pop stalled, then drain in order
    bus.pop_ready = 1'b0;
    for (int i = 0; i < int'(DEP) + 2; i++) push_word(DW'(i));
    repeat (3) tick();
    chk("fill_full",       32'(fifo_full),      32'd1);
    chk("fill_push_ready", 32'(bus.push_ready), 32'd0);
    chk("fill_depth",      32'(fifo_depth),     32'(exp_q.size()));
    chk("fill_model_size", 32'(exp_q.size()),   32'(DEP + 2));
    bus.push      = 1'b1;
    bus.push_data = DW'(16'hBEEF);
    repeat (3) tick();
    bus.push = 1'b0;
    drain("fill");

    // Contention: push held, pop_ready held, SRAM port alternates
    bus.pop_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(DW'(16'h0300 + i));
    repeat (4) tick();
    bus.pop_ready = 1'b1;
    bus.push      = 1'b1;
    bus.push_data = DW'($urandom);
    prev_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      we_s   = bus.mem_we;
      re_s   = bus.mem_re;
      took_s = bus.push && bus.push_ready;
      if (i > 0) chk("contention_alt", 32'({we_s, re_s}), 32'({!prev_we, prev_we}));
      prev_we = we_s;
      tick();
      if (took_s) bus.push_data = DW'($urandom);
    end
    bus.push = 1'b0;
    drain("contention");

    // Pointer wrap under random stalls
    run_random("wrap", 3000, 70, 60);
    drain("wrap");

    // Power loss with 10 stored entries
    bus.pop_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(DW'(16'h0100 + i));
    repeat (4) tick();
    chk("pl_depth_before", 32'(fifo_depth), 32'd10);
    bus.mem_pwr_enable_b = 1'b1;
    bus.push             = 1'b1;
    bus.push_data        = DW'(16'hDEAD);
    @(negedge clk);
    chk("pl_push_ready", 32'(bus.push_ready), 32'd0);
    chk("pl_mem_we",     32'(bus.mem_we),     32'd0);
    chk("pl_mem_re",     32'(bus.mem_re),     32'd0);
    tick();
    // Only the two prefetched words in the output buffer survive
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    chk("pl_err",        32'(err_pwr_loss),   32'd1);
    chk("pl_depth",      32'(fifo_depth),     32'(exp_q.size()));
    chk("pl_push_ready_after", 32'(bus.push_ready), 32'd0);
    repeat (3) tick();
    chk("pl_depth_hold", 32'(fifo_depth),     32'd2);
    bus.push             = 1'b0;
    bus.mem_pwr_enable_b = 1'b0;
    tick();
    run_random("pl_restore", 200, 60, 50);
    drain("pl_restore");
    chk("pl_err_sticky", 32'(err_pwr_loss), 32'd1);

    // Reset while a read is on the SRAM port
    bus.pop_ready = 1'b0;
    for (int i = 0; i < 20; i++) push_word(DW'(16'h0700 + i));
    bus.pop_ready = 1'b1;
    bus.push      = 1'b1;
    bus.push_data = DW'(16'h0777);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_re) begin
        seen      = 1'b1;
        clk_rst_n = 1'b0;
      end else begin
        tick();
      end
    end
    chk("mid_rst_seen_re", 32'(seen), 32'd1);
    #1;
    exp_q.delete();
    check_reset_outputs("mid_rst");
    tick();
    tick();
    chk("mid_rst_hold_push_ready", 32'(bus.push_ready), 32'd0);
    @(negedge clk);
    clk_rst_n = 1'b1;
    #1;
    chk("mid_rst_release_ready", 32'(bus.push_ready), 32'd0);
    bus.push = 1'b0;
    tick();
    run_random("post_rst", 100, 60, 60);
    drain("post_rst");

    // Error flag clears only through reset
    apply_reset();
    chk("final_err",   32'(err_pwr_loss), 32'd0);
    chk("final_empty", 32'(fifo_empty),   32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
